bist_signature_checker: RTL and testbench
=========================================

// Module: bist_signature_checker
// PURPOSE
//  Response side of the BIST datapath; sits downstream of the test-sequencing controller.
//  Compacts parallel CUT outputs into a MISR when MISR_En is high.
//  Compacts the serial scan-out stream into a SISA when SISA_En is high.
//  On done, compares both signatures and the capture count against golden values, then latches pass/fail.
// PARAMETERS
//  OutWidth    43            CUT parallel output width = MISR width
//  SisaWidth   16            SISA register width
//  MisrPoly    43'h0000000063 MISR feedback taps (Galois, bit i XOR-ed when MSB=1)
//  SisaPoly    16'h002D      SISA feedback taps
//  MisrSeed    0             MISR value after any reset
//  SisaSeed    0             SISA value after any reset
//  GoldenMisr  0             expected final MISR signature
//  GoldenSisa  0             expected final SISA signature
//  NumOfRounds 50            expected number of MISR captures
// PORTS
//  clk        in   1          clock, rising edge
//  rstIn      in   1          reset, asynchronous, active-high
//  rstSig     in   1          synchronous clear (driven by controller rstOut)
//  MISR_En    in   1          capture misrIn this cycle
//  misrIn     in   OutWidth   CUT parallel response
//  SISA_En    in   1          capture sisaIn this cycle
//  sisaIn     in   1          scan-chain serial output bit
//  done       in   1          test sequence finished (level)
//  misrSig    out  OutWidth   current MISR contents
//  sisaSig    out  SisaWidth  current SISA contents
//  capCount   out  16         MISR captures since reset, saturating
//  cmpValid   out  1          pass/fail are valid
//  pass       out  1          all three checks matched
//  fail       out  1          at least one check mismatched
// BEHAVIOUR
//  Reset (rstIn async, or rstSig sync, same effect):
//   - state=RUN; misrSig=MisrSeed; sisaSig=SisaSeed; capCount=0; cmpValid=pass=fail=0.
//   - rstSig overrides every other input in the same cycle, in any state.
//  MISR update, RUN and MISR_En: sig <= {sig[W-2:0],1'b0} ^ (sig[W-1] ? MisrPoly : 0) ^ misrIn.
//  SISA update, RUN and SISA_En: same form with SisaPoly; data is {SisaWidth-1 zeros, sisaIn}.
//  MISR_En and SISA_En are independent; both may update in the same cycle.
//  capCount: +1 per MISR capture in RUN; holds at 16'hFFFF (no wrap).
//  FSM:
//   - RUN: compaction enabled. done=1 -> COMPARE. A MISR_En/SISA_En on that same edge is still applied.
//   - COMPARE (1 cycle): enables ignored. Registers match = (misrSig==GoldenMisr) & (sisaSig==GoldenSisa) & (capCount==NumOfRounds).
//     Sets pass=match, fail=~match, cmpValid=1, then -> RESULT.
//   - RESULT: all outputs frozen; enables and done ignored; exit only via rstSig/rstIn.
//   - Illegal state encoding -> RUN, with registers cleared as for reset.
//  Latency: done first sampled at edge N -> cmpValid=1 after edge N+1; pass/fail stable until reset.
//  pass and fail are never both 1; both are 0 whenever cmpValid=0.
//  done deasserting during COMPARE/RESULT has no effect.
//  Reset mid-compaction discards partial signatures; no residue survives.
// STRUCTURE
//  bist_pkg (shared with controller and PRPG):
//   - FSM state localparams RUN/COMPARE/RESULT (2-bit).
//   - Default MISR/SISA polynomials and seeds.
//  Sub-module bist_lfsr_compactor:
//   - Params Width, Poly, Seed. Ports clk, rstIn, clr, en, din[Width], sig.
//   - Instantiated twice: MISR, and SISA with din zero-extended from sisaIn.
//  Top level holds the FSM, capCount and the compare/result registers.
// TESTING (bench overrides OutWidth=4, SisaWidth=4, MisrPoly=SisaPoly=4'h3, seeds=0)
//  1. rstIn pulse, then idle -> misrSig=0, sisaSig=0, capCount=0, cmpValid=pass=fail=0.
//  2. MISR_En with misrIn=4'h8, then MISR_En with misrIn=4'h0 -> misrSig 4'h8 then 4'h3; capCount=2.
//  3. SISA_En, sisaIn=1,1,0 -> sisaSig 4'h1, 4'h3, 4'h6; misrSig unchanged.
//  4. GoldenMisr=4'h3, GoldenSisa=4'h6, NumOfRounds=2; run 2+3 then done -> cmpValid after 2 edges, pass=1, fail=0.
//  5. Same run, golden MISR 4'h4 -> fail=1, pass=0; later MISR_En/done toggles leave every output unchanged.
//  6. rstSig in RESULT, and rstSig together with MISR_En in RUN -> all cleared; that cycle's capture is dropped.

Source files
------------

// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bist_pkg
// Brief    : Shared BIST types and defaults (checker, controller, PRPG).
// Revision : 1.0
// ============================================================================
package bist_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COMPARE = 2'd1,
        RESULT  = 2'd2
    } state_e;

    localparam int unsigned    CAP_W             = 16;
    localparam logic [42:0]    MISR_POLY_DEFAULT = 43'h0000000063;
    localparam logic [15:0]    SISA_POLY_DEFAULT = 16'h002D;
    localparam logic [42:0]    MISR_SEED_DEFAULT = '0;
    localparam logic [15:0]    SISA_SEED_DEFAULT = '0;

endpackage
`default_nettype wire

// File: rtl/bist_signature_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : bist_signature_checker_if
// Brief    : Controller-to-checker bundle: compaction controls and results.
// Revision : 1.0
// ============================================================================
interface bist_signature_checker_if #(
    parameter int OutWidth  = 43,
    parameter int SisaWidth = 16
);
    logic                 rstSig;
    logic                 MISR_En;
    logic [OutWidth-1:0]  misrIn;
    logic                 SISA_En;
    logic                 sisaIn;
    logic                 done;
    logic [OutWidth-1:0]  misrSig;
    logic [SisaWidth-1:0] sisaSig;
    logic [15:0]          capCount;
    logic                 cmpValid;
    logic                 pass;
    logic                 fail;

    modport master (
        output rstSig, MISR_En, misrIn, SISA_En, sisaIn, done,
        input  misrSig, sisaSig, capCount, cmpValid, pass, fail
    );

    modport slave (
        input  rstSig, MISR_En, misrIn, SISA_En, sisaIn, done,
        output misrSig, sisaSig, capCount, cmpValid, pass, fail
    );
endinterface
`default_nettype wire

// File: rtl/bist_lfsr_compactor.sv
`default_nettype none
// ============================================================================
// Module   : bist_lfsr_compactor
// Brief    : Galois-style signature register (MISR or SISA) with sync clear.
// Revision : 1.0
// ============================================================================
module bist_lfsr_compactor #(
    parameter int               Width = 43,
    parameter logic [Width-1:0] Poly  = '0,
    parameter logic [Width-1:0] Seed  = '0
) (
    input  wire logic             clk,
    input  wire logic             rstIn,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic [Width-1:0] din,
    output logic      [Width-1:0] sig
);

    logic [Width-1:0] sig_q;
    logic [Width-1:0] sig_d;

    // Clear wins over capture so a reset cycle never leaves residue.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = Seed;
        end else if (en) begin
            sig_d = {sig_q[Width-2:0], 1'b0} ^ (sig_q[Width-1] ? Poly : '0) ^ din;
        end
    end

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            sig_q <= Seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule
`default_nettype wire

// File: rtl/bist_signature_checker.sv
`default_nettype none
// ============================================================================
// Module   : bist_signature_checker
// Brief    : BIST response compaction (MISR + SISA) with golden compare.
// Revision : 1.0
// ============================================================================
module bist_signature_checker
    import bist_pkg::*;
#(
    parameter int                   OutWidth    = 43,
    parameter int                   SisaWidth   = 16,
    parameter logic [OutWidth-1:0]  MisrPoly    = OutWidth'(MISR_POLY_DEFAULT),
    parameter logic [SisaWidth-1:0] SisaPoly    = SisaWidth'(SISA_POLY_DEFAULT),
    parameter logic [OutWidth-1:0]  MisrSeed    = OutWidth'(MISR_SEED_DEFAULT),
    parameter logic [SisaWidth-1:0] SisaSeed    = SisaWidth'(SISA_SEED_DEFAULT),
    parameter logic [OutWidth-1:0]  GoldenMisr  = '0,
    parameter logic [SisaWidth-1:0] GoldenSisa  = '0,
    parameter int                   NumOfRounds = 50
) (
    input  wire logic                    clk,
    input  wire logic                    rstIn,
    bist_signature_checker_if.slave      bus
);

    state_e             state_q, state_d;
    logic [CAP_W-1:0]   cap_q, cap_d;
    logic               valid_q, valid_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;

    logic [OutWidth-1:0]  w_misr_sig;
    logic [SisaWidth-1:0] w_sisa_sig;
    logic                 w_illegal;
    logic                 w_clr;
    logic                 w_run;
    logic                 w_match;

    // An unreachable encoding is treated exactly like a synchronous clear.
    assign w_illegal = !(state_q inside {RUN, COMPARE, RESULT});
    assign w_clr     = bus.rstSig | w_illegal;
    assign w_run     = (state_q == RUN);
    assign w_match   = (w_misr_sig == GoldenMisr) &&
                       (w_sisa_sig == GoldenSisa) &&
                       (cap_q == CAP_W'(NumOfRounds));

    bist_lfsr_compactor #(
        .Width (OutWidth),
        .Poly  (MisrPoly),
        .Seed  (MisrSeed)
    ) u_misr (
        .clk   (clk),
        .rstIn (rstIn),
        .clr   (w_clr),
        .en    (w_run & bus.MISR_En),
        .din   (bus.misrIn),
        .sig   (w_misr_sig)
    );

    bist_lfsr_compactor #(
        .Width (SisaWidth),
        .Poly  (SisaPoly),
        .Seed  (SisaSeed)
    ) u_sisa (
        .clk   (clk),
        .rstIn (rstIn),
        .clr   (w_clr),
        .en    (w_run & bus.SISA_En),
        .din   ({{(SisaWidth-1){1'b0}}, bus.sisaIn}),
        .sig   (w_sisa_sig)
    );

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        valid_d = valid_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        if (w_clr) begin
            state_d = RUN;
            cap_d   = '0;
            valid_d = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.MISR_En && (cap_q != {CAP_W{1'b1}})) begin
                        cap_d = cap_q + 1'b1;
                    end
                    if (bus.done) begin
                        state_d = COMPARE;
                    end
                end
                COMPARE: begin
                    valid_d = 1'b1;
                    pass_d  = w_match;
                    fail_d  = ~w_match;
                    state_d = RESULT;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            state_q <= RUN;
            cap_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.misrSig  = w_misr_sig;
    assign bus.sisaSig  = w_sisa_sig;
    assign bus.capCount = cap_q;
    assign bus.cmpValid = valid_q;
    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_signature_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bist_signature_checker
// Brief    : Scoreboard bench; two checkers differing only in golden MISR.
// Revision : 1.0
// ============================================================================
module tb_bist_signature_checker;

    logic clk = 1'b0;
    logic rstIn;
    always #5 clk = ~clk;

    bist_signature_checker_if #(.OutWidth(4), .SisaWidth(4)) ifA ();
    bist_signature_checker_if #(.OutWidth(4), .SisaWidth(4)) ifB ();

    bist_signature_checker #(
        .OutWidth(4), .SisaWidth(4), .MisrPoly(4'h3), .SisaPoly(4'h3),
        .MisrSeed(4'h0), .SisaSeed(4'h0),
        .GoldenMisr(4'h3), .GoldenSisa(4'h6), .NumOfRounds(2)
    ) u_dut_a (.clk(clk), .rstIn(rstIn), .bus(ifA));

    bist_signature_checker #(
        .OutWidth(4), .SisaWidth(4), .MisrPoly(4'h3), .SisaPoly(4'h3),
        .MisrSeed(4'h0), .SisaSeed(4'h0),
        .GoldenMisr(4'h4), .GoldenSisa(4'h6), .NumOfRounds(2)
    ) u_dut_b (.clk(clk), .rstIn(rstIn), .bus(ifB));

    typedef struct packed {
        logic [3:0]  misr;
        logic [3:0]  sisa;
        logic [15:0] cap;
        logic        v;
        logic        p;
        logic        f;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state; st: 0 run, 1 compare, 2 result
    int          m_st;
    logic [3:0]  m_misr, m_sisa;
    logic [15:0] m_cap;
    logic        m_v, m_pa, m_fa, m_pb, m_fb;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] lfsr4(input logic [3:0] s, input logic [3:0] d);
        logic [3:0] r;
        r = {s[2:0], 1'b0} ^ d;
        if (s[3]) r = r ^ 4'h3;
        return r;
    endfunction

    task automatic m_reset();
        m_st = 0; m_misr = 4'h0; m_sisa = 4'h0; m_cap = 16'h0;
        m_v = 0; m_pa = 0; m_fa = 0; m_pb = 0; m_fb = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.misr = m_misr; e.sisa = m_sisa; e.cap = m_cap;
        e.v = m_v; e.p = m_pa; e.f = m_fa;
        sb_a.push_back(e);
        e.p = m_pb; e.f = m_fb;
        sb_b.push_back(e);
    endtask

    task automatic model_edge(input logic rs, input logic me, input logic [3:0] mi,
                              input logic se, input logic si, input logic dn);
        logic ma, mb;
        if (rs) begin
            m_reset();
        end else if (m_st == 0) begin
            if (me) begin
                m_misr = lfsr4(m_misr, mi);
                if (m_cap != 16'hFFFF) m_cap = m_cap + 16'd1;
            end
            if (se) m_sisa = lfsr4(m_sisa, {3'b000, si});
            if (dn) m_st = 1;
        end else if (m_st == 1) begin
            ma = (m_misr == 4'h3) && (m_sisa == 4'h6) && (m_cap == 16'd2);
            mb = (m_misr == 4'h4) && (m_sisa == 4'h6) && (m_cap == 16'd2);
            m_v = 1; m_pa = ma; m_fa = !ma; m_pb = mb; m_fb = !mb;
            m_st = 2;
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb_a.size() == 0 || sb_b.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_a.pop_front();
            chk("A_misr", 32'(ifA.misrSig),  32'(e.misr));
            chk("A_sisa", 32'(ifA.sisaSig),  32'(e.sisa));
            chk("A_cap",  32'(ifA.capCount), 32'(e.cap));
            chk("A_vld",  32'(ifA.cmpValid), 32'(e.v));
            chk("A_pass", 32'(ifA.pass),     32'(e.p));
            chk("A_fail", 32'(ifA.fail),     32'(e.f));
            e = sb_b.pop_front();
            chk("B_misr", 32'(ifB.misrSig),  32'(e.misr));
            chk("B_sisa", 32'(ifB.sisaSig),  32'(e.sisa));
            chk("B_cap",  32'(ifB.capCount), 32'(e.cap));
            chk("B_vld",  32'(ifB.cmpValid), 32'(e.v));
            chk("B_pass", 32'(ifB.pass),     32'(e.p));
            chk("B_fail", 32'(ifB.fail),     32'(e.f));
        end
    endtask

    task automatic drive(input logic rs, input logic me, input logic [3:0] mi,
                         input logic se, input logic si, input logic dn);
        ifA.rstSig = rs; ifA.MISR_En = me; ifA.misrIn = mi;
        ifA.SISA_En = se; ifA.sisaIn = si; ifA.done = dn;
        ifB.rstSig = rs; ifB.MISR_En = me; ifB.misrIn = mi;
        ifB.SISA_En = se; ifB.sisaIn = si; ifB.done = dn;
    endtask

    task automatic step(input logic rs, input logic me, input logic [3:0] mi,
                        input logic se, input logic si, input logic dn);
        @(negedge clk);
        drive(rs, me, mi, se, si, dn);
        model_edge(rs, me, mi, se, si, dn);
        push_exp();
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    // Asserted between edges so the clear is visible without a clock.
    task automatic async_reset();
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 0);
        rstIn = 1'b1;
        m_reset();
        push_exp();
        #1;
        compare_pop();
        @(negedge clk);
        rstIn = 1'b0;
    endtask

    initial begin
        rstIn = 1'b0;
        drive(0, 0, 4'h0, 0, 0, 0);
        m_reset();

        async_reset();
        step(0, 0, 4'h0, 0, 0, 0);

        step(0, 1, 4'h8, 0, 0, 0);
        step(0, 1, 4'h0, 0, 0, 0);

        step(0, 0, 4'h0, 1, 1, 0);
        step(0, 0, 4'h0, 1, 1, 0);
        step(0, 0, 4'h0, 1, 0, 0);

        step(0, 0, 4'h0, 0, 0, 1);
        step(0, 0, 4'h0, 0, 0, 0);

        step(0, 1, 4'h5, 1, 1, 1);
        step(0, 1, 4'h9, 0, 0, 0);
        step(0, 0, 4'h0, 1, 1, 1);

        step(1, 1, 4'h7, 1, 1, 0);
        step(0, 1, 4'h8, 1, 1, 0);
        step(1, 1, 4'h5, 1, 1, 0);
        step(0, 0, 4'h0, 0, 0, 0);

        step(0, 1, 4'h4, 1, 1, 0);
        async_reset();

        step(0, 1, 4'h8, 1, 1, 0);
        step(0, 1, 4'h0, 1, 1, 0);
        step(0, 0, 4'h0, 1, 0, 1);
        step(0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 4'h0, 0, 0, 0);

        step(1, 0, 4'h0, 0, 0, 0);
        step(0, 1, 4'h8, 0, 0, 0);
        step(0, 1, 4'h0, 0, 0, 0);
        step(0, 1, 4'h0, 1, 1, 1);
        step(0, 0, 4'h0, 0, 0, 0);

        step(1, 0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i == 17));
        end

        chk("sb_drained", 32'(sb_a.size() + sb_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
